// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand-forward selection for a 5-stage pipeline.
// Tracks rd/wen/is_load of the instructions in EX, MEM and WB.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } trk_t;

    trk_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;
    logic             stall_c, ex_load;

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] x;
        x = ~(a ^ b);
        return &x;
    endfunction

    function automatic logic is_producer(input trk_t t);
        return t.vld & t.wen & (t.rd != 5'd0);
    endfunction

    function automatic logic src_match(input logic vld, input logic used,
                                       input logic [4:0] rs, input trk_t t);
        return used & vld & addr_eq(rs, t.rd) & is_producer(t);
    endfunction

    // EX is the youngest producer and wins; a WB hit reads the write-first regfile.
    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic ex_is_load,
                                           input logic m_mem, input logic m_wb);
        if (m_ex && !ex_is_load) return FWD_MEM;
        else if (m_mem)          return FWD_WB;
        else if (m_wb)           return FWD_RF;
        else                     return FWD_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        m1_ex   = src_match(id_valid, id_rs1_used, id_rs1, ex_q);
        m1_mem  = src_match(id_valid, id_rs1_used, id_rs1, mem_q);
        m1_wb   = src_match(id_valid, id_rs1_used, id_rs1, wb_q);
        m2_ex   = src_match(id_valid, id_rs2_used, id_rs2, ex_q);
        m2_mem  = src_match(id_valid, id_rs2_used, id_rs2, mem_q);
        m2_wb   = src_match(id_valid, id_rs2_used, id_rs2, wb_q);
        // Flush and reset both override a load-use stall.
        stall_c = (m1_ex | m2_ex) & ex_q.is_load & ~flush & ~rst;
        ex_load = id_valid & ~stall_c & ~flush;
        ex_d    = {ex_load, id_rd, id_rd_wen, id_is_load};
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwd_a_d = ex_load ? fwd_sel(m1_ex, ex_q.is_load, m1_mem, m1_wb) : FWD_RF;
        fwd_b_d = ex_load ? fwd_sel(m2_ex, ex_q.is_load, m2_mem, m2_wb) : FWD_RF;
        cnt_d   = stall_c ? sat_inc(cnt_q) : cnt_q;
    end

    // Only the valid bits, selects and counter are reset; tracker payload just follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q.vld  <= 1'b0;
            mem_q.vld <= 1'b0;
            wb_q.vld  <= 1'b0;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall     = stall_c;
    assign ex_fwd_a  = fwd_a_q;
    assign ex_fwd_b  = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; a second narrow-counter instance
// exercises counter saturation within a short run.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall, stall4;
    logic [1:0]  fa, fb, fa4, fb4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .ex_fwd_a(fa), .ex_fwd_b(fb), .stall_cnt(cnt)
    );

    hazard_forward_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .flush(flush),
        .stall(stall4), .ex_fwd_a(fa4), .ex_fwd_b(fb4), .stall_cnt(cnt4)
    );

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_cnt = 16'd0;
    logic [3:0]  m_cnt4 = 4'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ID/flush/rst, check stall combinationally, then check
    // the registered outputs that the scoreboard predicted for this edge.
    task automatic cyc(input logic r, input logic fl, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic es, input logic [1:0] efa, input logic [1:0] efb,
                       input string tag);
        exp_t e;
        rst = r; flush = fl; id_valid = v;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_wen = wen; id_is_load = ld;
        #1;
        chk({tag, "/stall"}, {15'd0, stall}, {15'd0, es});
        chk({tag, "/stall_n"}, {15'd0, stall4}, {15'd0, es});
        if (r) begin
            m_cnt = 16'd0; m_cnt4 = 4'd0;
        end else if (es) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
        end
        e.fa = r ? 2'b00 : efa;
        e.fb = r ? 2'b00 : efb;
        e.cnt = m_cnt; e.cnt4 = m_cnt4; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "/fwd_a"}, {14'd0, fa}, {14'd0, e.fa});
        chk({e.tag, "/fwd_b"}, {14'd0, fb}, {14'd0, e.fb});
        chk({e.tag, "/fwd_a_n"}, {14'd0, fa4}, {14'd0, e.fa});
        chk({e.tag, "/cnt"}, cnt, e.cnt);
        chk({e.tag, "/cnt_n"}, {12'd0, cnt4}, {12'd0, e.cnt4});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, "idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // reset
        cyc(1, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 2'b00, 2'b00, "reset0");
        cyc(1, 0, 1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 0, 2'b00, 2'b00, "reset1");

        // ALU RAW distance 1
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 2'b00, 2'b00, "alu_prod");
        cyc(0, 0, 1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 2'b01, 2'b00, "alu_raw");
        idle(3);

        // distance-2 RAW on rs2
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0, 2'b00, 2'b00, "d2_prod");
        cyc(0, 0, 1, 5'd10, 1, 5'd11, 1, 5'd9, 1, 0, 0, 2'b00, 2'b00, "d2_indep");
        cyc(0, 0, 1, 5'd12, 1, 5'd7, 1, 5'd13, 1, 0, 0, 2'b00, 2'b10, "d2_raw");
        idle(3);

        // EX beats MEM when both hold the same rd
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0, 2'b00, 2'b00, "pri_old");
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0, 2'b00, 2'b00, "pri_new");
        cyc(0, 0, 1, 5'd7, 1, 5'd7, 1, 5'd13, 1, 0, 0, 2'b01, 2'b01, "pri_raw");
        idle(3);

        // distance-3 (WB) gives no forward
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd14, 1, 0, 0, 2'b00, 2'b00, "wb_prod");
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd15, 1, 0, 0, 2'b00, 2'b00, "wb_i1");
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd16, 1, 0, 0, 2'b00, 2'b00, "wb_i2");
        cyc(0, 0, 1, 5'd14, 1, 5'd2, 1, 5'd17, 1, 0, 0, 2'b00, 2'b00, "wb_raw");
        idle(3);

        // load-use: one stall cycle with a bubble, then MEM->WB forward
        cyc(0, 0, 1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0, 2'b00, 2'b00, "lu_load");
        cyc(0, 0, 1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 1, 2'b00, 2'b00, "lu_stall");
        cyc(0, 0, 1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 0, 2'b10, 2'b00, "lu_fwd");
        idle(3);

        // x0 never matches, for ALU and load producers
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 2'b00, 2'b00, "x0_prod");
        cyc(0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, "x0_cons");
        idle(3);
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 1, 0, 2'b00, 2'b00, "x0_load");
        cyc(0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, "x0_lcons");
        idle(3);

        // unused sources and invalid ID never match
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd20, 1, 0, 0, 2'b00, 2'b00, "un_prod");
        cyc(0, 0, 1, 5'd21, 1, 5'd20, 0, 5'd8, 1, 0, 0, 2'b00, 2'b00, "un_rs2");
        idle(3);
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd22, 1, 1, 0, 2'b00, 2'b00, "un_load");
        cyc(0, 0, 1, 5'd23, 1, 5'd22, 0, 5'd8, 1, 0, 0, 2'b00, 2'b00, "un_lrs2");
        idle(3);
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 0, 2'b00, 2'b00, "iv_load");
        cyc(0, 0, 0, 5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, "iv_cons");
        idle(3);

        // flush beats stall and kills forwarding
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 0, 2'b00, 2'b00, "fl_load");
        cyc(0, 1, 1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 0, 2'b00, 2'b00, "fl_stall");
        idle(3);
        cyc(0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 2'b00, 2'b00, "fl_prod");
        cyc(0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd10, 1, 0, 0, 2'b00, 2'b00, "fl_alu");
        idle(3);

        // chain of self-dependent loads: stalls every other cycle
        for (int i = 0; i <= 40; i++) begin
            if (i == 0)
                cyc(0, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, 2'b00, 2'b00, "sat");
            else if (i % 2 == 1)
                cyc(0, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 1, 2'b00, 2'b00, "sat");
            else
                cyc(0, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, 2'b10, 2'b00, "sat");
        end
        chk("sat_held_n", {12'd0, cnt4}, 16'h000F);

        // reset while a stall is pending, then the ID instruction is gone
        cyc(1, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, 2'b00, 2'b00, "rst_mid");
        cyc(0, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, 2'b00, 2'b00, "post_rst");
        cyc(0, 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 1, 2'b00, 2'b00, "post_stall");
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed first as below.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-002 The block SHALL provide these ID-stage inputs:
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register addresses.
- id_rs1_used, id_rs2_used  in  1 each  source is actually read.
- id_rd  in  5  destination register address.
- id_rd_wen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
REQ-003 The block SHALL provide this input:
- flush  in  1  taken branch/jump resolved in EX; kills the ID instruction.
REQ-004 The block SHALL provide these outputs:
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- ex_fwd_a, ex_fwd_b  out  2 each  registered operand selects for the instruction now in EX: 00 regfile, 01 MEM-stage result, 10 WB-stage result, 11 unused.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-005 The block SHALL keep three tracker stages, EX, MEM and WB, each holding {valid, rd, wen, is_load}.
REQ-006 On each non-reset edge the block SHALL shift MEM to WB and EX to MEM.
REQ-007 On the same edge EX SHALL load the ID fields when id_valid & ~stall & ~flush, and SHALL otherwise load a bubble (valid=0).
REQ-008 A tracker stage SHALL be a producer only when valid & wen & (rd != 0); register x0 SHALL never match and SHALL never be forwarded.
REQ-009 Source match: srcN_match_S SHALL equal idN_used & id_valid & (id_rsN == rd_S) & producer_S, for N in {1,2} and S in {EX, MEM}.
- Each address comparison is a 5-bit equality per bit: XNOR, then AND-reduce.
REQ-010 stall SHALL be combinational: (src1_match_EX | src2_match_EX) & EX.is_load & ~flush.
REQ-011 A load-use stall SHALL last exactly 1 cycle: on the next cycle the load is in MEM and is no longer in EX.
REQ-012 ex_fwd_x SHALL be registered on each edge from the current ID comparison:
- 01 if the source matches EX and EX is not a load;
- else 10 if the source matches MEM;
- else 00.
- The EX match has priority over the MEM match because it is the youngest producer.
REQ-013 When EX loads a bubble (stall, flush, or ~id_valid), ex_fwd_a and ex_fwd_b SHALL register 00.
REQ-014 A match against WB SHALL produce no forward.
- The register file is write-first within a cycle, so ID reads the WB value directly.
REQ-015 If flush and stall conditions occur in the same cycle, flush SHALL win: stall=0 and EX gets a bubble.
REQ-016 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-017 The block SHALL contain no combinational path from any input to ex_fwd_a, ex_fwd_b or stall_cnt.
- stall is the only combinational output.

Reset
REQ-018 When rst=1 at an edge, all tracker valid bits, ex_fwd_a, ex_fwd_b and stall_cnt SHALL become 0.
REQ-019 During a rst cycle, stall SHALL be 0 because all trackers are invalid.
REQ-020 An instruction in ID during a rst cycle SHALL be discarded (EX = bubble after reset).
REQ-021 Reset asserted mid-stall SHALL clear the pending stall on the same edge.

Verification
REQ-022 ALU RAW:
- Stimulus: cycle 0 ID = add x5 (wen=1); cycle 1 ID = sub rs1=x5.
- Required response: stall=0 in cycle 1; ex_fwd_a=01 in cycle 2.
REQ-023 Distance-2 RAW:
- Stimulus: producer x7, one independent instruction, then consumer rs2=x7.
- Required response: ex_fwd_b=10 when the consumer is in EX.
REQ-024 Load-use:
- Stimulus: lw x3, then add rs1=x3.
- Required response: stall=1 for exactly 1 cycle; EX bubble with fwd 00; then ex_fwd_a=10 for the add; stall_cnt=1.
REQ-025 x0 and unused source:
- Stimulus: producer rd=x0 followed by consumer rs1=x0; separately, a match with rs2_used=0.
- Required response: stall=0 and fwd=00 in all cases.
REQ-026 Flush over stall:
- Stimulus: load in EX, dependent instruction in ID, flush=1.
- Required response: stall=0; EX becomes a bubble; stall_cnt unchanged.
REQ-027 Saturation and reset:
- Stimulus: force 65536+ stall cycles, then rst=1 mid-stall.
- Required response: stall_cnt holds 16'hFFFF; after the reset edge stall_cnt=0, fwd=00 and stall=0.
